// File: rtl/mdu.sv
// rtl/mdu.sv - iterative 32-iteration multiply/divide unit with HI/LO registers
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   a, b           operands (rs, rt), captured when start is accepted
//   op             00 mult, 01 multu, 10 div, 11 divu
//   start          request, accepted only while idle
//   hi_we, lo_we   mthi / mtlo write strobes, wdata is the write value
//   busy           an operation is in flight (combinational from state)
//   done           one-cycle pulse, HI/LO hold the new result
//   hi, lo         HI/LO result registers
//
// Build option: define MDU_DIV_EN to compile in the divider datapath.
// Without it, div/divu requests are ignored entirely.

module mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  input  logic            start,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;      // {partial product / remainder, multiplier / dividend-quotient}
  logic [31:0] opnd_q;     // multiplicand or divisor
  logic        res_neg_q;  // negate product / quotient at FIX
  logic        rem_neg_q;  // negate remainder at FIX
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept;
  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] acc_d;
  logic [31:0] fix_hi_d, fix_lo_d;

  // Multiply step: conditional add into the upper half, then shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step  = {mul_sum, acc_q[31:1]};

`ifdef MDU_DIV_EN
  logic        is_div_q;
  logic        div_zero_q;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] div_step;

  assign accept = start && (state_q == S_IDLE);

  // Restoring divide: shift the next dividend bit into the 33-bit partial
  // remainder and keep the trial difference only if it did not go negative.
  assign div_shift = acc_q[63:31];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_step  = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                   : {div_trial[31:0], acc_q[30:0], 1'b1};
  assign acc_d     = is_div_q ? div_step : mul_step;
`else
  assign accept = start && (state_q == S_IDLE) && !op[1];
  assign acc_d  = mul_step;
`endif

  always_comb begin
    fix_hi_d = res_neg_q ? (~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)}) : acc_q[63:32];
    fix_lo_d = res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      if (div_zero_q) begin
        // opnd_q was loaded with |a| for a zero divisor, so this restores a.
        fix_hi_d = rem_neg_q ? (~opnd_q + 32'd1) : opnd_q;
        fix_lo_d = 32'hFFFF_FFFF;
      end else begin
        fix_hi_d = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        fix_lo_d = res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_RUN;
            cnt_q     <= 5'd0;
            res_neg_q <= is_signed && (a[31] ^ b[31]);
            rem_neg_q <= is_signed && a[31];
            acc_q     <= {32'd0, abs_b};
            opnd_q    <= abs_a;
`ifdef MDU_DIV_EN
            is_div_q   <= op[1];
            div_zero_q <= op[1] && (b == 32'd0);
            if (op[1]) begin
              acc_q  <= {32'd0, abs_a};
              opnd_q <= (b == 32'd0) ? abs_a : abs_b;
            end
`endif
          end else if (!start) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, wdata;
  logic [1:0]  op;
  logic        start, hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request just after an edge; it is accepted at the next edge (E0).
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; returns in the done cycle.
  task automatic wait_done(output int lat);
    lat = 999;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    start_op(o, x, y);
    wait_done(lat);
  endtask

  int lat, lat2;
  logic saw_busy, saw_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // mult -2 * 3
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat);
    chk("mult_latency", lat, 33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    @(posedge clk); #1;
    chk("mult_done_one_cycle", done, 0);

    // multu 0xFFFFFFFE * 3
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, lat);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // multu large: 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    // start and mthi during RUN are ignored
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b01; a = 32'd7; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat);
    chk("run_ignore_latency", lat + 6, 33);
    chk("run_ignore_hi", hi, 32'hFFFF_FFFF);
    chk("run_ignore_lo", lo, 32'hFFFF_FFFA);

    // mthi + mtlo in IDLE
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mtx_hi", hi, 32'hA5A5_A5A5);
    chk("mtx_lo", lo, 32'hA5A5_A5A5);

`ifdef MDU_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_neg_latency", lat, 33);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_wrap_lo", lo, 32'h8000_0000);
    chk("div_wrap_hi", hi, 32'h0000_0000);

    run_op(2'b11, 32'd100, 32'd0, lat);
    chk("divu_zero_latency", lat, 33);
    chk("divu_zero_hi", hi, 32'd100);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    // back-to-back: issued in the done cycle
    run_op(2'b11, 32'd100, 32'd7, lat2);
    chk("b2b_latency", lat2, 33);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat);
    chk("div_zero_neg_hi", hi, 32'hFFFF_FFF9);
    chk("div_zero_neg_lo", lo, 32'hFFFF_FFFF);

    // restore HI/LO to a known nonzero value for the abort check
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
`else
    // div request is ignored when the divider is not built
    saw_busy = 1'b0; saw_done = 1'b0;
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (busy) saw_busy = 1'b1;
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("nodiv_busy", saw_busy, 0);
    chk("nodiv_done", saw_done, 0);
    chk("nodiv_hi", hi, 32'hA5A5_A5A5);
`endif

    // reset mid-multu aborts
    start_op(2'b01, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
